// File: rtl/proc_pkg.sv
// Shared definitions for the main-memory port arbiter: word sizes, the
// read-owner encoding and the arbiter state set.
package proc_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    CPU_PRI    = 2'd0,
    HOST_FORCE = 2'd1,
    HOST_ONLY  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester's memory port: request/write bundle towards the arbiter,
// grant and read-return back to the requester.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift pipe that follows each read through the RAM
// so the returning word can be steered to whoever issued it.
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  proc_pkg::owner_e i_own,
  output logic             o_vld,
  output proc_pkg::owner_e o_own
);
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_own;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_own <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_own[0] <= i_own;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
    end
  end

  assign o_vld = r_vld[RD_LAT-1];
  assign o_own = proc_pkg::owner_e'(r_own[RD_LAT-1]);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU control path and the host loader,
// with host anti-starvation and host-exclusive access while the CPU is halted.
module mem_port_arbiter #(
  parameter int ADDR_W     = proc_pkg::ADDR_W,
  parameter int DATA_W     = proc_pkg::DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave host,
  input  logic              cpu_halted,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              starve_evt
);
  import proc_pkg::*;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  arb_state_e        r_state;
  logic [3:0]        r_cnt;
  logic              r_starve_evt;
  logic              r_cpu_rvalid;
  logic              r_host_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;

  logic       w_cpu_gnt;
  logic       w_host_gnt;
  logic [3:0] w_cnt_next;
  logic       w_tag_vld;
  owner_e     w_tag_own;

  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    case (r_state)
      CPU_PRI: begin
        w_cpu_gnt  = cpu.req;
        w_host_gnt = host.req & ~cpu.req;
      end
      HOST_FORCE: begin
        w_host_gnt = host.req;
        w_cpu_gnt  = cpu.req & ~host.req;
      end
      HOST_ONLY:  w_host_gnt = host.req;
      default:    w_cpu_gnt  = 1'b0;
    endcase
  end

  // Counts consecutive denied host cycles; any grant or withdrawal restarts it.
  always_comb begin
    if (!host.req || w_host_gnt)
      w_cnt_next = '0;
    else if (r_cnt == CNT_MAX)
      w_cnt_next = r_cnt;
    else
      w_cnt_next = r_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= CPU_PRI;
      r_cnt        <= '0;
      r_starve_evt <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_next;
      // Registered, so the pulse lands in the cycle after the forced grant.
      r_starve_evt <= (r_state == HOST_FORCE) && w_host_gnt;
      case (r_state)
        CPU_PRI: begin
          if (cpu_halted)
            r_state <= HOST_ONLY;
          else if (w_cnt_next == CNT_MAX)
            r_state <= HOST_FORCE;
        end
        HOST_FORCE: r_state <= cpu_halted ? HOST_ONLY : CPU_PRI;
        HOST_ONLY:  if (!cpu_halted) r_state <= CPU_PRI;
        default:    r_state <= CPU_PRI;
      endcase
    end
  end

  assign ram_en    = w_cpu_gnt | w_host_gnt;
  assign ram_we    = w_host_gnt ? host.we : (w_cpu_gnt & cpu.we);
  assign ram_addr  = w_host_gnt ? host.addr  : cpu.addr;
  assign ram_wdata = w_host_gnt ? host.wdata : cpu.wdata;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_vld (ram_en & ~ram_we),
    .i_own (w_host_gnt ? OWN_HOST : OWN_CPU),
    .o_vld (w_tag_vld),
    .o_own (w_tag_own)
  );

  // Read return stage: capture RAM data for the tagged owner only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_cpu_rdata   <= '0;
      r_host_rdata  <= '0;
    end else begin
      r_cpu_rvalid  <= w_tag_vld && (w_tag_own == OWN_CPU);
      r_host_rvalid <= w_tag_vld && (w_tag_own == OWN_HOST);
      if (w_tag_vld && (w_tag_own == OWN_CPU))
        r_cpu_rdata <= ram_rdata;
      if (w_tag_vld && (w_tag_own == OWN_HOST))
        r_host_rdata <= ram_rdata;
    end
  end

  assign cpu.gnt     = w_cpu_gnt;
  assign host.gnt    = w_host_gnt;
  assign cpu.rvalid  = r_cpu_rvalid;
  assign host.rvalid = r_host_rvalid;
  assign cpu.rdata   = r_cpu_rdata;
  assign host.rdata  = r_host_rdata;
  assign starve_evt  = r_starve_evt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT = 1 and one
// with RD_LAT = 3, driven by the same requester stimulus, each with its own RAM.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we, cpu_halted;
  logic [11:0] cpu_addr, host_addr;
  logic [15:0] cpu_wdata, host_wdata;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) cpu1_if ();
  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) host1_if ();
  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) cpu3_if ();
  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) host3_if ();

  assign cpu1_if.req   = cpu_req;   assign cpu3_if.req   = cpu_req;
  assign cpu1_if.we    = cpu_we;    assign cpu3_if.we    = cpu_we;
  assign cpu1_if.addr  = cpu_addr;  assign cpu3_if.addr  = cpu_addr;
  assign cpu1_if.wdata = cpu_wdata; assign cpu3_if.wdata = cpu_wdata;
  assign host1_if.req   = host_req;   assign host3_if.req   = host_req;
  assign host1_if.we    = host_we;    assign host3_if.we    = host_we;
  assign host1_if.addr  = host_addr;  assign host3_if.addr  = host_addr;
  assign host1_if.wdata = host_wdata; assign host3_if.wdata = host_wdata;

  logic        ram_en1, ram_we1, starve_evt1;
  logic [11:0] ram_addr1;
  logic [15:0] ram_wdata1, ram_rdata1;
  logic        ram_en3, ram_we3, starve_evt3;
  logic [11:0] ram_addr3;
  logic [15:0] ram_wdata3, ram_rdata3;

  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst), .cpu(cpu1_if), .host(host1_if), .cpu_halted(cpu_halted),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1), .starve_evt(starve_evt1)
  );

  mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst), .cpu(cpu3_if), .host(host3_if), .cpu_halted(cpu_halted),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .starve_evt(starve_evt3)
  );

  // Unwritten words read back as {4'hA, addr}, except 0x010 which holds 0xBEEF.
  function automatic logic [15:0] init_val(input logic [11:0] a);
    return (a == 12'h010) ? 16'hBEEF : {4'hA, a};
  endfunction

  bit [15:0] mem1 [4096];
  bit        wr1  [4096];
  always @(posedge clk) begin
    if (ram_en1 && !ram_we1)
      ram_rdata1 <= wr1[ram_addr1] ? mem1[ram_addr1] : init_val(ram_addr1);
    if (ram_en1 && ram_we1) begin
      mem1[ram_addr1] <= ram_wdata1;
      wr1[ram_addr1]  <= 1'b1;
    end
  end

  bit [15:0]   mem3 [4096];
  bit          wr3  [4096];
  logic [15:0] rd3_p0, rd3_p1;
  always @(posedge clk) begin
    rd3_p0 <= (ram_en3 && !ram_we3) ? (wr3[ram_addr3] ? mem3[ram_addr3] : init_val(ram_addr3)) : 16'h0;
    rd3_p1     <= rd3_p0;
    ram_rdata3 <= rd3_p1;
    if (ram_en3 && ram_we3) begin
      mem3[ram_addr3] <= ram_wdata3;
      wr3[ram_addr3]  <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_rv1 [8] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  logic [1:0]  exp_rv3 [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
  logic [15:0] exp_d1  [8] = '{16'h0, 16'h0, 16'h1234, 16'hBEEF, 16'h5555, 16'hA055, 16'h0, 16'h0};
  logic [15:0] exp_d3  [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h1234, 16'hBEEF, 16'h5555, 16'hA055};
  logic [11:0] alt_addr [4] = '{12'h020, 12'h010, 12'h030, 12'h055};

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cpu_halted = 1'b0;

    // Reset state
    repeat (2) next();
    chk("rst_rvalid", {cpu1_if.rvalid, host1_if.rvalid}, 2'b00);
    chk("rst_starve", starve_evt1, 1'b0);
    chk("rst_ram_en", ram_en1, 1'b0);
    chk("rst_state", u_dut1.r_state, proc_pkg::CPU_PRI);
    rst = 1'b1;
    repeat (2) next();

    // CPU read of 0x010 (0xBEEF)
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    #1 chk("t1_gnt", {cpu1_if.gnt, host1_if.gnt}, 2'b10);
    chk("t1_ram_en_we", {ram_en1, ram_we1}, 2'b10);
    chk("t1_ram_addr", ram_addr1, 12'h010);
    next(); cpu_req = 1'b0;
    #1 chk("t1_rvalid_early", cpu1_if.rvalid, 1'b0);
    next();
    chk("t1_cpu_rvalid", cpu1_if.rvalid, 1'b1);
    chk("t1_cpu_rdata", cpu1_if.rdata, 16'hBEEF);
    chk("t1_host_rvalid", host1_if.rvalid, 1'b0);
    next();
    chk("t1_rvalid_pulse", cpu1_if.rvalid, 1'b0);
    repeat (4) next();

    // Starvation: both requesting, host forced through on the 5th cycle
    cpu_req = 1'b1; cpu_addr = 12'h011;
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h012;
    for (int c = 1; c <= 4; c++) begin
      #1 chk($sformatf("t2_cpu_wins_%0d", c), {cpu1_if.gnt, host1_if.gnt}, 2'b10);
      next();
    end
    #1 chk("t2_forced_gnt", {cpu1_if.gnt, host1_if.gnt}, 2'b01);
    chk("t2_evt_not_yet", starve_evt1, 1'b0);
    next(); host_req = 1'b0;
    #1 chk("t2_cpu_again", {cpu1_if.gnt, host1_if.gnt}, 2'b10);
    chk("t2_starve_evt", starve_evt1, 1'b1);
    next(); cpu_req = 1'b0;
    #1 chk("t2_evt_pulse", starve_evt1, 1'b0);
    chk("t2_host_rvalid", {cpu1_if.rvalid, host1_if.rvalid}, 2'b01);
    chk("t2_host_rdata", host1_if.rdata, 16'hA012);
    repeat (5) next();

    // CPU halted: host owns the RAM even with cpu_req high
    cpu_halted = 1'b1;
    next();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h020; host_wdata = 16'h1234;
    #1 chk("t3_state", u_dut1.r_state, proc_pkg::HOST_ONLY);
    chk("t3_gnt", {cpu1_if.gnt, host1_if.gnt}, 2'b01);
    chk("t3_ram_we", {ram_en1, ram_we1}, 2'b11);
    chk("t3_ram_addr", ram_addr1, 12'h020);
    chk("t3_ram_wdata", ram_wdata1, 16'h1234);
    next(); host_req = 1'b0; host_we = 1'b0;
    #1 chk("t3_cpu_blocked", {cpu1_if.gnt, host1_if.gnt, ram_en1}, 3'b000);
    next(); cpu_halted = 1'b0;
    #1 chk("t3_still_host_only", {cpu1_if.gnt, host1_if.gnt}, 2'b00);
    next();
    chk("t3_cpu_resume", {cpu1_if.gnt, host1_if.gnt}, 2'b10);
    next(); cpu_req = 1'b0;
    repeat (5) next();

    // Host write then CPU read of the same address on the next cycle
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h030; host_wdata = 16'h5555;
    #1 chk("t4_host_gnt", {cpu1_if.gnt, host1_if.gnt}, 2'b01);
    next(); host_req = 1'b0; host_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
    #1 chk("t4_cpu_gnt", {cpu1_if.gnt, host1_if.gnt}, 2'b10);
    next(); cpu_req = 1'b0;
    next();
    chk("t4_rvalid", cpu1_if.rvalid, 1'b1);
    chk("t4_rdata", cpu1_if.rdata, 16'h5555);
    repeat (6) next();

    // Alternating CPU/host reads, checked on both latencies
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        cpu_req  = (k % 2 == 0);
        host_req = (k % 2 == 1);
        cpu_addr  = alt_addr[k];
        host_addr = alt_addr[k];
      end else begin
        cpu_req  = 1'b0;
        host_req = 1'b0;
      end
      #1;
      chk($sformatf("t5_rv1_%0d", k), {cpu1_if.rvalid, host1_if.rvalid}, exp_rv1[k]);
      chk($sformatf("t5_rv3_%0d", k), {cpu3_if.rvalid, host3_if.rvalid}, exp_rv3[k]);
      if (exp_rv1[k][1]) chk($sformatf("t5_cd1_%0d", k), cpu1_if.rdata, exp_d1[k]);
      if (exp_rv1[k][0]) chk($sformatf("t5_hd1_%0d", k), host1_if.rdata, exp_d1[k]);
      if (exp_rv3[k][1]) chk($sformatf("t5_cd3_%0d", k), cpu3_if.rdata, exp_d3[k]);
      if (exp_rv3[k][0]) chk($sformatf("t5_hd3_%0d", k), host3_if.rdata, exp_d3[k]);
      next();
    end
    repeat (3) next();

    // Reset while reads are in flight
    cpu_req = 1'b1; cpu_addr = 12'h010;
    next(); cpu_req = 1'b0; host_req = 1'b1; host_addr = 12'h011;
    next(); host_req = 1'b0;
    #1 rst = 1'b0;
    #1 chk("t6_rv_in_rst", {cpu1_if.rvalid, host1_if.rvalid, cpu3_if.rvalid, host3_if.rvalid}, 4'b0000);
    chk("t6_rdata1", {cpu1_if.rdata, host1_if.rdata}, 32'h0);
    chk("t6_outs", {ram_en1, ram_we1, starve_evt1, cpu1_if.gnt, host1_if.gnt}, 5'b00000);
    chk("t6_state1", u_dut1.r_state, proc_pkg::CPU_PRI);
    chk("t6_state3", u_dut3.r_state, proc_pkg::CPU_PRI);
    repeat (2) next();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("t6_no_rv_%0d", c),
             {cpu1_if.rvalid, host1_if.rvalid, cpu3_if.rvalid, host3_if.rvalid}, 4'b0000);
      next();
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h077;
    #1 chk("t6_first_gnt1", {cpu1_if.gnt, ram_en1}, 2'b11);
    chk("t6_first_gnt3", {cpu3_if.gnt, ram_en3}, 2'b11);
    next(); cpu_req = 1'b0;
    next();
    chk("t6_post_rvalid", cpu1_if.rvalid, 1'b1);
    chk("t6_post_rdata", cpu1_if.rdata, 16'hA077);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
